// File: rtl/result_display.sv
// ---------------------------------------------------------------------------
// result_display
//   Accepts one unsigned arithmetic result plus its overflow flag over a
//   valid/ready handshake. An iterative double-dabble engine turns it into
//   three BCD digits, one shift per clock. The digits are then time-multiplexed
//   onto a common 7-segment display with leading-zero blanking. The overflow
//   LED follows the flag of the result currently shown.
//
// Parameters
//   WIDTH        result width, 4..8 (three BCD digits always suffice)
//   REFRESH_DIV  clk cycles each digit stays lit, >= 2
//
// Ports
//   clk        in   clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   res_valid  in   res_data/res_ovf valid
//   res_ready  out  block can accept a result (high only while idle)
//   res_data   in   unsigned result magnitude [WIDTH-1:0]
//   res_ovf    in   overflow flag of the result
//   busy       out  conversion in progress
//   seg_n      out  segments {g,f,e,d,c,b,a}, active-low
//   an_n       out  digit enables, active-low one-hot; [0]=units [2]=hundreds
//   led_ovf    out  overflow LED for the displayed result
// ---------------------------------------------------------------------------
module result_display #(
  parameter int WIDTH       = 8,
  parameter int REFRESH_DIV = 50000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             res_valid,
  output logic             res_ready,
  input  logic [WIDTH-1:0] res_data,
  input  logic             res_ovf,
  output logic             busy,
  output logic [6:0]       seg_n,
  output logic [2:0]       an_n,
  output logic             led_ovf
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam int REF_W = $clog2(REFRESH_DIV);
  localparam int SH_W  = 12 + WIDTH;

  typedef enum logic [1:0] {IDLE, CONV, LOAD} state_t;

  state_t             state, state_nxt;
  logic [SH_W-1:0]    shreg;        // {bcd[11:0], bin[WIDTH-1:0]}
  logic [SH_W-1:0]    shifted;
  logic [11:0]        bcd_adj;
  logic [CNT_W-1:0]   bit_cnt;
  logic               ovf_q;
  logic               accept;

  logic [11:0]        digits_q, digits_nxt;
  logic [REF_W-1:0]   ref_cnt;
  logic               ref_wrap;
  logic [1:0]         idx, idx_nxt;
  logic               led_nxt;
  logic [6:0]         seg_nxt;
  logic [2:0]         an_nxt;

  // -------------------------------------------------------------------------
  // Control FSM
  // -------------------------------------------------------------------------
  // NOTE: state and all other flops use non-blocking assignments so every
  // register samples pre-edge values; blocking here would create order races.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave a variable unassigned and infer a latch.
  always_comb begin
    state_nxt = state;
    res_ready = 1'b0;
    busy      = 1'b0;
    case (state)
      IDLE: begin
        res_ready = 1'b1;
        if (res_valid) state_nxt = CONV;
      end
      CONV: begin
        busy = 1'b1;
        // The edge that performs the last shift also moves us to LOAD.
        if (bit_cnt == CNT_W'(1)) state_nxt = LOAD;
      end
      LOAD: begin
        busy      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign accept = res_valid && res_ready;

  // -------------------------------------------------------------------------
  // Double-dabble engine: correct each BCD nibble, then shift {bcd,bin} left.
  // -------------------------------------------------------------------------
  always_comb begin
    bcd_adj = shreg[SH_W-1 -: 12];
    for (int i = 0; i < 3; i++) begin
      if (bcd_adj[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_adj[4*i +: 4] + 4'd3;
    end
    shifted = {bcd_adj, shreg[WIDTH-1:0]} << 1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg   <= '0;
      bit_cnt <= '0;
      ovf_q   <= 1'b0;
    end else if (accept) begin
      shreg   <= {12'd0, res_data};
      bit_cnt <= CNT_W'(WIDTH);
      ovf_q   <= res_ovf;
    end else if (state == CONV) begin
      shreg   <= shifted;
      bit_cnt <= bit_cnt - 1'b1;
    end
  end

  // -------------------------------------------------------------------------
  // Display: digit registers, free-running refresh, registered seg_n/an_n.
  // seg_n and an_n are encoded from the next-cycle index and digits so both
  // change on the same edge as the values they represent.
  // -------------------------------------------------------------------------
  function automatic logic [6:0] seg_encode(input logic [3:0] d);
    case (d)
      4'd0:    return 7'h40;
      4'd1:    return 7'h79;
      4'd2:    return 7'h24;
      4'd3:    return 7'h30;
      4'd4:    return 7'h19;
      4'd5:    return 7'h12;
      4'd6:    return 7'h02;
      4'd7:    return 7'h78;
      4'd8:    return 7'h00;
      4'd9:    return 7'h10;
      default: return 7'h7F;
    endcase
  endfunction

  assign ref_wrap   = (ref_cnt == REF_W'(REFRESH_DIV - 1));
  assign idx_nxt    = ref_wrap ? ((idx == 2'd2) ? 2'd0 : idx + 2'd1) : idx;
  assign digits_nxt = (state == LOAD) ? shreg[SH_W-1 -: 12] : digits_q;
  assign led_nxt    = (state == LOAD) ? ovf_q : led_ovf;

  always_comb begin
    seg_nxt = 7'h7F;
    an_nxt  = 3'b111;
    case (idx_nxt)
      2'd0: begin
        an_nxt  = 3'b110;
        seg_nxt = seg_encode(digits_nxt[3:0]);
      end
      2'd1: begin
        an_nxt = 3'b101;
        if (digits_nxt[11:8] != 4'd0 || digits_nxt[7:4] != 4'd0)
          seg_nxt = seg_encode(digits_nxt[7:4]);
      end
      2'd2: begin
        an_nxt = 3'b011;
        if (digits_nxt[11:8] != 4'd0) seg_nxt = seg_encode(digits_nxt[11:8]);
      end
      default: ;
    endcase
  end

  // NOTE: the digit registers are a handful of flops, so they are reset like
  // any other state; the reset value is what makes the display show "0".
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ref_cnt  <= '0;
      idx      <= 2'd0;
      digits_q <= '0;
      led_ovf  <= 1'b0;
      seg_n    <= 7'h40;
      an_n     <= 3'b110;
    end else begin
      ref_cnt  <= ref_wrap ? '0 : ref_cnt + 1'b1;
      idx      <= idx_nxt;
      digits_q <= digits_nxt;
      led_ovf  <= led_nxt;
      seg_n    <= seg_nxt;
      an_n     <= an_nxt;
    end
  end

endmodule

// File: tb/tb_result_display.sv
// ---------------------------------------------------------------------------
// tb_result_display
//   Drives results into result_display (WIDTH=8, REFRESH_DIV=4). A driver
//   pushes the expected value/flag into a scoreboard at each accepted
//   handshake; a monitor pops it when busy drops and, every cycle, compares
//   an_n, seg_n, led_ovf and res_ready against a decimal-arithmetic model.
// ---------------------------------------------------------------------------
module tb_result_display;

  localparam int WIDTH       = 8;
  localparam int REFRESH_DIV = 4;
  localparam int LAT         = WIDTH + 1;   // busy cycles per conversion

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             res_valid = 1'b0;
  logic             res_ready;
  logic [WIDTH-1:0] res_data = '0;
  logic             res_ovf = 1'b0;
  logic             busy;
  logic [6:0]       seg_n;
  logic [2:0]       an_n;
  logic             led_ovf;

  always #5 clk = ~clk;

  result_display #(.WIDTH(WIDTH), .REFRESH_DIV(REFRESH_DIV)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .res_ovf   (res_ovf),
    .busy      (busy),
    .seg_n     (seg_n),
    .an_n      (an_n),
    .led_ovf   (led_ovf)
  );

  typedef struct {
    int value;
    bit ovf;
  } exp_t;

  exp_t     sb[$];
  exp_t     popped;
  int       n_checks = 0;
  int       n_pass   = 0;
  int       cur_val  = 0;
  bit       cur_ovf  = 1'b0;
  int       busy_cnt = 0;
  int       cyc      = 0;
  longint   last_acc = 0;
  logic [6:0] seg_tab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                               7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Expected segments for digit position d (0 units, 1 tens, 2 hundreds).
  function automatic logic [6:0] exp_seg(input int v, input int d);
    int h, t, u;
    h = v / 100;
    t = (v / 10) % 10;
    u = v % 10;
    case (d)
      0:       return seg_tab[u];
      1:       return (h == 0 && t == 0) ? 7'h7F : seg_tab[t];
      default: return (h == 0) ? 7'h7F : seg_tab[h];
    endcase
  endfunction

  function automatic logic [2:0] exp_an(input int c);
    int d;
    d = (c / REFRESH_DIV) % 3;
    return ~(3'b001 << d);
  endfunction

  // Clock edges seen since reset was released.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  // Monitor
  always @(negedge clk) begin
    if (!rst_n) begin
      sb.delete();
      cur_val  = 0;
      cur_ovf  = 1'b0;
      busy_cnt = 0;
    end else begin
      if (busy) begin
        busy_cnt++;
      end else if (busy_cnt > 0) begin
        check("busy_len", busy_cnt, LAT);
        busy_cnt = 0;
        if (sb.size() == 0) begin
          check("sb_underflow", sb.size(), 1);
        end else begin
          popped  = sb.pop_front();
          cur_val = popped.value;
          cur_ovf = popped.ovf;
        end
      end
      check("an_n", an_n, exp_an(cyc));
      check("seg_n", seg_n, exp_seg(cur_val, (cyc / REFRESH_DIV) % 3));
      check("led_ovf", led_ovf, cur_ovf);
      check("res_ready", res_ready, !busy);
    end
  end

  // Called at a negedge; returns at the negedge following the accepting edge.
  task automatic send(input int v, input bit o);
    int waited;
    waited    = 0;
    res_valid = 1'b1;
    res_data  = WIDTH'(v);
    res_ovf   = o;
    while (!res_ready && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    if (!res_ready) begin
      check("accept_timeout", waited, 0);
      res_valid = 1'b0;
      return;
    end
    @(posedge clk);
    sb.push_back('{v, o});
    last_acc = $time;
    @(negedge clk);
    res_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int waited;
    waited = 0;
    while (busy && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    if (busy) check("idle_timeout", waited, 0);
  endtask

  task automatic sweep();
    repeat (3 * REFRESH_DIV + 1) @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    longint t1;
    int v, gap;
    bit o;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_an_n", an_n, 3'b110);
    check("rst_seg_n", seg_n, 7'h40);
    check("rst_ready", res_ready, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_led", led_ovf, 1'b0);
    #2 rst_n = 1'b1;
    @(negedge clk);

    // Full-scale value
    send(255, 1'b0); wait_idle(); sweep();
    // Leading-zero blanking
    send(7, 1'b0);   wait_idle(); sweep();
    send(0, 1'b0);   wait_idle(); sweep();
    // Overflow set then cleared
    send(128, 1'b1); wait_idle(); sweep();
    send(3, 1'b0);   wait_idle();
    check("ovf_cleared", led_ovf, 1'b0);
    sweep();

    // Second result held while busy: accepted the cycle after LOAD
    send(77, 1'b1);
    t1 = last_acc;
    send(150, 1'b0);
    check("b2b_spacing", 32'(int'((last_acc - t1) / 10)), WIDTH + 2);
    wait_idle(); sweep();

    // Reset in the middle of a conversion
    send(200, 1'b0);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_an_n", an_n, 3'b110);
    check("mid_rst_seg_n", seg_n, 7'h40);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_ready", res_ready, 1'b1);
    check("mid_rst_led", led_ovf, 1'b0);
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    sweep(); sweep();

    // Randomized results, some back-to-back, refresh keeps running
    for (int i = 0; i < 40; i++) begin
      v   = int'($urandom_range(0, 255));
      o   = 1'($urandom_range(0, 1));
      gap = int'($urandom_range(0, 3));
      send(v, o);
      if (gap != 0) repeat (gap * 5) @(negedge clk);
    end
    wait_idle();
    sweep();
    check("sb_drained", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
